// File: rtl/spg_pkg.sv
// Shared definitions for sync_pulse_gen.
//   SPG_WIDTH       : default counter / register width
//   SPG_ADDR_*      : register select codes on ADDR (3 is reserved)
//   spg_regs_t      : one full register set (period, start, end)
//   spg_write()     : merges a single register write into a register set
package spg_pkg;

  localparam int SPG_WIDTH = 9;

  localparam logic [1:0] SPG_ADDR_PERIOD = 2'd0;
  localparam logic [1:0] SPG_ADDR_START  = 2'd1;
  localparam logic [1:0] SPG_ADDR_END    = 2'd2;

  typedef struct packed {
    logic [SPG_WIDTH-1:0] period_val;
    logic [SPG_WIDTH-1:0] start_val;
    logic [SPG_WIDTH-1:0] end_val;
  } spg_regs_t;

  // The reserved address leaves the set untouched.
  function automatic spg_regs_t spg_write(spg_regs_t r, logic [1:0] addr,
                                          logic [SPG_WIDTH-1:0] d);
    spg_regs_t n;
    n = r;
    case (addr)
      SPG_ADDR_PERIOD: n.period_val = d;
      SPG_ADDR_START:  n.start_val  = d;
      SPG_ADDR_END:    n.end_val    = d;
      default:         n = r;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sync_pulse_gen_if.sv
// Bus bundle between a CPU-side driver and sync_pulse_gen.
//   EN    : count enable            WR   : register write strobe
//   ADDR  : register select         DIN  : write data
//   J     : set pulse (active high) KL   : clear pulse (active low)
//   WRAP  : one-cycle wrap pulse    COUNT: current line count
// master = CPU/timing controller side, slave = sync_pulse_gen.
interface sync_pulse_gen_if #(
  parameter int WIDTH = spg_pkg::SPG_WIDTH
);
  import spg_pkg::*;

  logic             EN;
  logic             WR;
  logic [1:0]       ADDR;
  logic [WIDTH-1:0] DIN;
  logic             J;
  logic             KL;
  logic             WRAP;
  logic [WIDTH-1:0] COUNT;

  modport master (
    output EN, WR, ADDR, DIN,
    input  J, KL, WRAP, COUNT
  );

  modport slave (
    input  EN, WR, ADDR, DIN,
    output J, KL, WRAP, COUNT
  );

endinterface

// File: rtl/spg_regbank.sv
// Double-buffered register bank for sync_pulse_gen.
// CPU writes land in the shadow set and raise a pending flag; the whole
// shadow set moves to the active set on a counter wrap so a frame never
// sees a half-updated configuration.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   wr_i, addr_i, din_i : register write port
//   wrap_i        : counter wraps on this edge (EN=1 and COUNT==PERIOD)
//   active_o      : register set used by the compare logic
//   pending_o     : shadow holds writes not yet transferred
module spg_regbank
  import spg_pkg::*;
#(
  parameter int PERIOD_RST = 511,
  parameter int START_RST  = 0,
  parameter int END_RST    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wr_i,
  input  logic [1:0]           addr_i,
  input  logic [SPG_WIDTH-1:0] din_i,
  input  logic                 wrap_i,
  output spg_regs_t            active_o,
  output logic                 pending_o
);

  localparam spg_regs_t RST_REGS = '{
    period_val: SPG_WIDTH'(PERIOD_RST),
    start_val:  SPG_WIDTH'(START_RST),
    end_val:    SPG_WIDTH'(END_RST)
  };

  spg_regs_t shadow_q, shadow_d;
  spg_regs_t active_q, active_d;
  logic      pending_q, pending_d;

  always_comb begin
    shadow_d  = wr_i ? spg_write(shadow_q, addr_i, din_i) : shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (wrap_i) begin
      // shadow_d already carries a write on this same edge, so it is
      // transferred too and nothing is left pending.
      active_d  = shadow_d;
      pending_d = 1'b0;
    end else if (wr_i && (addr_i != 2'd3)) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q  <= RST_REGS;
      active_q  <= RST_REGS;
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  assign active_o  = active_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/sync_pulse_gen.sv
// Programmable sync/blank edge generator. A loadable line counter is
// compared with the active START/END registers to produce the J (set) and
// KL (active-low clear) inputs of a downstream JK stage, plus a WRAP pulse.
// All outputs are registered: a match on COUNT shows up one CLK later.
//   CLK    : system clock
//   RESETL : asynchronous active-low reset
//   bus    : sync_pulse_gen_if slave (EN, WR, ADDR, DIN in; J, KL, WRAP,
//            COUNT out)
module sync_pulse_gen
  import spg_pkg::*;
#(
  parameter int WIDTH      = SPG_WIDTH,
  parameter int PERIOD_RST = 511,
  parameter int START_RST  = 0,
  parameter int END_RST    = 16
) (
  input  logic              CLK,
  input  logic              RESETL,
  sync_pulse_gen_if.slave   bus
);

  spg_regs_t        active;
  logic             pending;
  logic [WIDTH-1:0] count_q, count_d;
  logic             j_q, j_d;
  logic             kl_q, kl_d;
  logic             wrap_q, wrap_d;

  spg_regbank #(
    .PERIOD_RST (PERIOD_RST),
    .START_RST  (START_RST),
    .END_RST    (END_RST)
  ) u_regs (
    .clk_i     (CLK),
    .rst_ni    (RESETL),
    .wr_i      (bus.WR),
    .addr_i    (bus.ADDR),
    .din_i     (bus.DIN),
    .wrap_i    (wrap_d),
    .active_o  (active),
    .pending_o (pending)
  );

  // Wrap only on an exact PERIOD match; a count above PERIOD simply rolls
  // over at 2^WIDTH without a wrap pulse or shadow transfer.
  always_comb begin
    wrap_d  = bus.EN && (count_q == active.period_val);
    j_d     = bus.EN && (count_q == active.start_val);
    kl_d    = !(bus.EN && (count_q == active.end_val));
    count_d = count_q;
    if (bus.EN) begin
      count_d = wrap_d ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      count_q <= '0;
      j_q     <= 1'b0;
      kl_q    <= 1'b1;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      j_q     <= j_d;
      kl_q    <= kl_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.COUNT = count_q;
  assign bus.J     = j_q;
  assign bus.KL    = kl_q;
  assign bus.WRAP  = wrap_q;

endmodule
